// File: rtl/calc_length_and_crc32_wide.sv
// Stream length counter and CRC-32 (gzip/IEEE, reflected 0xEDB88320) over up to
// BYTES byte lanes per beat. Lane 0 is first in stream order, and lanes whose
// keep flag is clear are skipped.
// Optional macro CALC_CRC_INPUT_REG_EN adds a reset-cleared input register
// stage. With it, latency is 2 cycles instead of 1.
module calc_length_and_crc32_wide #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned LEN_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_eos,
  input  logic               i_eob,
  input  logic [8*BYTES-1:0] i_data,
  input  logic [BYTES-1:0]   i_keep,
  output logic               o_valid,
  output logic               o_eos,
  output logic               o_eob,
  output logic [LEN_W-1:0]   o_stream_len,
  output logic [31:0]        o_stream_crc,
  output logic               o_len_wrap,
  output logic [15:0]        o_stream_cnt
);

  localparam logic [31:0] CrcPoly = 32'hEDB88320;

  logic               beat_en;
  logic               beat_eos;
  logic               beat_eob;
  logic [8*BYTES-1:0] beat_data;
  logic [BYTES-1:0]   beat_keep;

`ifdef CALC_CRC_INPUT_REG_EN
  logic               en_q;
  logic               eos_q;
  logic               eob_q;
  logic [8*BYTES-1:0] data_q;
  logic [BYTES-1:0]   keep_q;

  // Input register stage; reset drops any beat held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      eos_q  <= 1'b0;
      eob_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
    end else begin
      en_q   <= i_en;
      eos_q  <= i_eos;
      eob_q  <= i_eob;
      data_q <= i_data;
      keep_q <= i_keep;
    end
  end

  assign beat_en   = en_q;
  assign beat_eos  = eos_q;
  assign beat_eob  = eob_q;
  assign beat_data = data_q;
  assign beat_keep = keep_q;
`else
  assign beat_en   = i_en;
  assign beat_eos  = i_eos;
  assign beat_eob  = i_eob;
  assign beat_data = i_data;
  assign beat_keep = i_keep;
`endif

  // Fold one byte into a reflected CRC register, bit-serially.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      crc_q, crc_d;
  logic             wrap_q, wrap_d;
  logic             valid_q, valid_d;
  logic             eos_o_q, eos_o_d;
  logic             eob_o_q, eob_o_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  logic [31:0]      out_crc_q, out_crc_d;
  logic             out_wrap_q, out_wrap_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [31:0]      crc_fold;
  logic [3:0]       kept_cnt;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_next;
  logic             wrap_next;

  // Per-beat CRC fold over kept lanes, and the length sum with its carry-out.
  always_comb begin
    crc_fold = crc_q;
    kept_cnt = 4'd0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (beat_keep[k]) begin
        crc_fold = crc_byte(crc_fold, beat_data[8*k +: 8]);
        kept_cnt = kept_cnt + 4'd1;
      end
    end
    // At most 8 bytes per beat and LEN_W >= 16, so a beat carries out at most once.
    len_sum   = {1'b0, len_q} + {{(LEN_W-3){1'b0}}, kept_cnt};
    len_next  = len_sum[LEN_W-1:0];
    wrap_next = wrap_q | len_sum[LEN_W];
  end

  // Next-state: accumulate on a valid beat, publish and reload on end of stream.
  always_comb begin
    len_d      = len_q;
    crc_d      = crc_q;
    wrap_d     = wrap_q;
    out_len_d  = out_len_q;
    out_crc_d  = out_crc_q;
    out_wrap_d = out_wrap_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    eos_o_d    = beat_en & beat_eos;
    eob_o_d    = beat_en & beat_eob;
    if (beat_en) begin
      if (beat_eos) begin
        out_len_d  = len_next;
        out_crc_d  = ~crc_fold;
        out_wrap_d = wrap_next;
        cnt_d      = cnt_q + 16'd1;
        valid_d    = 1'b1;
        len_d      = '0;
        crc_d      = 32'hFFFFFFFF;
        wrap_d     = 1'b0;
      end else begin
        len_d  = len_next;
        crc_d  = crc_fold;
        wrap_d = wrap_next;
      end
    end
  end

  // State and output registers; reset wins over any beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      crc_q      <= 32'hFFFFFFFF;
      wrap_q     <= 1'b0;
      valid_q    <= 1'b0;
      eos_o_q    <= 1'b0;
      eob_o_q    <= 1'b0;
      out_len_q  <= '0;
      out_crc_q  <= '0;
      out_wrap_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      len_q      <= len_d;
      crc_q      <= crc_d;
      wrap_q     <= wrap_d;
      valid_q    <= valid_d;
      eos_o_q    <= eos_o_d;
      eob_o_q    <= eob_o_d;
      out_len_q  <= out_len_d;
      out_crc_q  <= out_crc_d;
      out_wrap_q <= out_wrap_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_eos        = eos_o_q;
  assign o_eob        = eob_o_q;
  assign o_stream_len = out_len_q;
  assign o_stream_crc = out_crc_q;
  assign o_len_wrap   = out_wrap_q;
  assign o_stream_cnt = cnt_q;

endmodule

// File: tb/tb_calc_length_and_crc32_wide.sv
// Bench for calc_length_and_crc32_wide: a default instance (LEN_W=32) and a
// LEN_W=16 instance share the stimulus. Each cycle is checked against a
// byte-queue reference model, with table vectors and hand sequences on top.
module tb_calc_length_and_crc32_wide;

`ifdef CALC_CRC_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, i_en, i_eos, i_eob;
  logic [31:0] i_data;
  logic [3:0]  i_keep;

  logic        a_valid, a_eos, a_eob, a_wrap;
  logic [31:0] a_len, a_crc;
  logic [15:0] a_cnt;
  logic        b_valid, b_eos, b_eob, b_wrap;
  logic [15:0] b_len;
  logic [31:0] b_crc;
  logic [15:0] b_cnt;

  always #5 clk = ~clk;

  calc_length_and_crc32_wide #(.BYTES(4), .LEN_W(32)) dut_a (
    .clk(clk), .rst(rst), .i_en(i_en), .i_eos(i_eos), .i_eob(i_eob), .i_data(i_data),
    .i_keep(i_keep), .o_valid(a_valid), .o_eos(a_eos), .o_eob(a_eob), .o_stream_len(a_len),
    .o_stream_crc(a_crc), .o_len_wrap(a_wrap), .o_stream_cnt(a_cnt)
  );

  calc_length_and_crc32_wide #(.BYTES(4), .LEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .i_en(i_en), .i_eos(i_eos), .i_eob(i_eob), .i_data(i_data),
    .i_keep(i_keep), .o_valid(b_valid), .o_eos(b_eos), .o_eob(b_eob), .o_stream_len(b_len),
    .o_stream_crc(b_crc), .o_len_wrap(b_wrap), .o_stream_cnt(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the open stream, total byte count, expected outputs.
  byte unsigned    m_q[$];
  longint unsigned m_total;
  logic            p_en, p_eos, p_eob;
  logic [31:0]     p_data;
  logic [3:0]      p_keep;
  logic            e_valid, e_eos, e_eob, e_wrap_a, e_wrap_b;
  logic [31:0]     e_len_a, e_crc;
  logic [15:0]     e_len_b, e_cnt;

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (m_q[i]) begin
      c = c ^ {24'h0, m_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model_edge(input logic r, en, eos, eob, input logic [31:0] d,
                            input logic [3:0] k);
    logic        x_en, x_eos, x_eob;
    logic [31:0] x_data;
    logic [3:0]  x_keep;
    if (r) begin
      m_q.delete();
      m_total = 0;
      {e_valid, e_eos, e_eob, e_wrap_a, e_wrap_b} = '0;
      e_len_a = '0; e_crc = '0; e_len_b = '0; e_cnt = '0;
      {p_en, p_eos, p_eob, p_data, p_keep} = '0;
    end else begin
`ifdef CALC_CRC_INPUT_REG_EN
      x_en = p_en; x_eos = p_eos; x_eob = p_eob; x_data = p_data; x_keep = p_keep;
      p_en = en; p_eos = eos; p_eob = eob; p_data = d; p_keep = k;
`else
      x_en = en; x_eos = eos; x_eob = eob; x_data = d; x_keep = k;
`endif
      e_valid = x_en & x_eos;
      e_eos   = x_en & x_eos;
      e_eob   = x_en & x_eob;
      if (x_en) begin
        for (int i = 0; i < 4; i++) begin
          if (x_keep[i]) begin
            m_q.push_back(x_data[8*i +: 8]);
            m_total++;
          end
        end
        if (x_eos) begin
          e_len_a  = m_total[31:0];
          e_wrap_a = (m_total >> 32) != 0;
          e_len_b  = m_total[15:0];
          e_wrap_b = (m_total >> 16) != 0;
          e_crc    = ref_crc();
          e_cnt    = e_cnt + 16'd1;
          m_q.delete();
          m_total = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_valid", a_valid, e_valid);
    chk("a_eos", a_eos, e_eos);
    chk("a_eob", a_eob, e_eob);
    chk("a_len", a_len, e_len_a);
    chk("a_crc", a_crc, e_crc);
    chk("a_wrap", a_wrap, e_wrap_a);
    chk("a_cnt", a_cnt, e_cnt);
    chk("b_valid", b_valid, e_valid);
    chk("b_eob", b_eob, e_eob);
    chk("b_len", b_len, e_len_b);
    chk("b_crc", b_crc, e_crc);
    chk("b_wrap", b_wrap, e_wrap_b);
    chk("b_cnt", b_cnt, e_cnt);
  endtask

  task automatic step(input logic r, en, eos, eob, input logic [31:0] d, input logic [3:0] k);
    rst = r; i_en = en; i_eos = eos; i_eob = eob; i_data = d; i_keep = k;
    @(posedge clk);
    model_edge(r, en, eos, eob, d, k);
    #1;
    compare_all();
  endtask

  task automatic drain();
    for (int j = 1; j < LAT; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  typedef struct {
    logic        en;
    logic        eos;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        chk;
    logic [31:0] len;
    logic [31:0] crc;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[12];

  initial begin
    // "123456789" in full beats, an empty stream, then sparse lanes with gaps.
    vt[0]  = '{1'b1, 1'b0, 32'h34333231, 4'hF, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 32'h38373635, 4'hF, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[2]  = '{1'b1, 1'b1, 32'hA5A5A539, 4'h1, 1'b1, 32'd9, 32'hCBF43926, 16'd1};
    vt[3]  = '{1'b1, 1'b1, 32'hDEADBEEF, 4'h0, 1'b1, 32'd0, 32'h00000000, 16'd2};
    vt[4]  = '{1'b1, 1'b0, 32'h32AA3155, 4'hA, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[5]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[6]  = '{1'b1, 1'b0, 32'h34003300, 4'hA, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[7]  = '{1'b0, 1'b0, 32'h12345678, 4'hF, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[8]  = '{1'b1, 1'b0, 32'h36113511, 4'hA, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[9]  = '{1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[10] = '{1'b1, 1'b0, 32'h38003700, 4'hA, 1'b0, 32'd0, 32'h0, 16'd0};
    vt[11] = '{1'b1, 1'b1, 32'h00003900, 4'h2, 1'b1, 32'd9, 32'hCBF43926, 16'd3};

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("reset_valid", a_valid, 1'b0);
    chk("reset_crc", a_crc, 32'h0);

    foreach (vt[i]) begin
      step(1'b0, vt[i].en, vt[i].eos, 1'b0, vt[i].data, vt[i].keep);
      if (vt[i].chk) begin
        drain();
        chk("vec_valid", a_valid, 1'b1);
        chk("vec_len", a_len, vt[i].len);
        chk("vec_crc", a_crc, vt[i].crc);
        chk("vec_cnt", a_cnt, vt[i].cnt);
      end
    end

    // Reset mid-stream, with a colliding eos beat, aborts the stream silently.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h64636261, 4'hF);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h68676665, 4'hF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h6C6B6A69, 4'h7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h11223344, 4'hF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hEEEEEE61, 4'h1);
    drain();
    chk("abort_valid", a_valid, 1'b1);
    chk("abort_len", a_len, 32'd1);
    chk("abort_crc", a_crc, 32'hE8B7BE43);
    chk("abort_cnt", a_cnt, 16'd1);

    // 65540 bytes wraps the 16-bit counter once; the next stream starts clean.
    for (int i = 0; i < 16384; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 4'hF);
    step(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 4'hF);
    drain();
    chk("wrap_b_len", b_len, 16'd4);
    chk("wrap_b_flag", b_wrap, 1'b1);
    chk("wrap_a_len", a_len, 32'd65540);
    chk("wrap_a_flag", a_wrap, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h1);
    drain();
    chk("post_wrap_len", b_len, 16'd1);
    chk("post_wrap_crc", b_crc, 32'hD202EF8D);
    chk("post_wrap_flag", b_wrap, 1'b0);

    // Random beats, gaps, eob and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom,
           4'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
